// File: rtl/cmd_word_issuer_pkg.sv
// Shared definitions for the DIF command bus: FSM state encoding, the
// default command codes (also used by the matching command decoders),
// the default inter-strobe gap and a saturating counter helper.
package dif_cmd_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;

    // Default command codes, one per request line
    localparam logic [16:1] CMD_CODE_1 = 16'h0001;
    localparam logic [16:1] CMD_CODE_2 = 16'h0002;
    localparam logic [16:1] CMD_CODE_3 = 16'h0003;
    localparam logic [16:1] CMD_CODE_4 = 16'h0004;

    // Idle cycles forced after each strobe so decoders leave their hold window
    localparam logic [8:1] GAP_CYC_DEFAULT = 8'd12;

    // Add a small increment to an 8-bit count, clamping at 255
    function automatic logic [8:1] sat_add8(input logic [8:1] base, input logic [3:1] inc);
        logic [9:1] sum;
        sum = {1'b0, base} + {6'd0, inc};
        return sum[9] ? 8'hFF : sum[8:1];
    endfunction

endpackage

// File: rtl/cmd_word_issuer_if.sv
// Host word handshake plus the outgoing Cmd_Out/Cmd_En command bus.
// master: the command issuer. slave: the host / bus observer.
interface cmd_word_issuer_if;
    logic [16:1] Host_Cmd_In;
    logic        Host_Cmd_Valid;
    logic        Host_Cmd_Ready;
    logic [16:1] Cmd_Out;
    logic        Cmd_En;

    modport master (
        input  Host_Cmd_In,
        input  Host_Cmd_Valid,
        output Host_Cmd_Ready,
        output Cmd_Out,
        output Cmd_En
    );

    modport slave (
        output Host_Cmd_In,
        output Host_Cmd_Valid,
        input  Host_Cmd_Ready,
        input  Cmd_Out,
        input  Cmd_En
    );
endinterface

// File: rtl/cmd_word_issuer_req_latch.sv
// cmd_req_latch: one request line. Registers the level for rising-edge
// detection, holds a pending flag until the issuer clears it, and pulses
// Drop when an edge arrives on a flag that is already pending.
// The edge register resets high so a level held through reset is not an edge.
module cmd_req_latch (
    input  logic Clk_In,
    input  logic Rst,
    input  logic Req_In,
    input  logic Clr,
    output logic Pending,
    output logic Drop
);
    logic Req_Q;
    logic Edge_Det;

    assign Edge_Det = Req_In & ~Req_Q;
    // An edge coinciding with the clear re-arms the flag, so it is not lost
    assign Drop     = Edge_Det & Pending & ~Clr;

    // Edge register and pending flag; a new edge wins over the issue clear
    always_ff @(posedge Clk_In) begin
        if (Rst) begin
            Req_Q   <= 1'b1;
            Pending <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            Req_Q <= Req_In;
            if (Edge_Det)
                Pending <= 1'b1;
            else if (Clr)
                Pending <= 1'b0;
        end
    end
endmodule

// File: rtl/cmd_word_issuer.sv
// cmd_word_issuer: turns request-line edges (and an optional host word)
// into spaced one-cycle Cmd_En strobes on the DIF command bus.
// Optional feature macro: CMD_ISSUER_HOST_PORT_EN enables the host word path;
// without it Host_Cmd_Ready is 0 and the host inputs are ignored.
module cmd_word_issuer
    import dif_cmd_pkg::*;
#(
    parameter logic [16:1] CMD_1   = CMD_CODE_1,
    parameter logic [16:1] CMD_2   = CMD_CODE_2,
    parameter logic [16:1] CMD_3   = CMD_CODE_3,
    parameter logic [16:1] CMD_4   = CMD_CODE_4,
    parameter logic [8:1]  GAP_CYC = GAP_CYC_DEFAULT
) (
    input  logic                     Clk_In,
    input  logic                     Rst,
    input  logic [4:1]               Req_In,
    cmd_word_issuer_if.master        Bus,
    output logic                     Busy,
    output logic [8:1]               Drop_Cnt
);
    logic [1:0]  State;
    logic [8:1]  Gap_Cnt;
    logic [16:1] Cmd_Out_Q;
    logic        Cmd_En_Q;
    logic [4:1]  Pending;
    logic [4:1]  Drop;
    logic [4:1]  Grant;
    logic [4:1]  Clr;
    logic [16:1] Sel_Word;
    logic        Host_Ready;
    logic        Host_Xfer;
    logic        Issue;
    logic [3:1]  Drop_Inc;

    for (genvar i = 1; i <= 4; i++) begin : g_req
        cmd_req_latch u_req (
            .Clk_In  (Clk_In),
            .Rst     (Rst),
            .Req_In  (Req_In[i]),
            .Clr     (Clr[i]),
            .Pending (Pending[i]),
            .Drop    (Drop[i])
        );
    end

`ifdef CMD_ISSUER_HOST_PORT_EN
    assign Host_Ready = (State == ST_IDLE) && (Pending == 4'b0000);
    assign Host_Xfer  = Host_Ready && Bus.Host_Cmd_Valid;
`else
    logic unused_host_bits;
    assign unused_host_bits = ^{Bus.Host_Cmd_In, Bus.Host_Cmd_Valid};
    assign Host_Ready = 1'b0;
    assign Host_Xfer  = 1'b0;
`endif

    // Fixed-priority arbiter: request 1 first, host word last
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        Grant = 4'b0000;
`ifdef CMD_ISSUER_HOST_PORT_EN
        Sel_Word = Bus.Host_Cmd_In;
`else
        Sel_Word = '0;
`endif
        if (Pending[1]) begin
            Grant[1] = 1'b1;
            Sel_Word = CMD_1;
        end else if (Pending[2]) begin
            Grant[2] = 1'b1;
            Sel_Word = CMD_2;
        end else if (Pending[3]) begin
            Grant[3] = 1'b1;
            Sel_Word = CMD_3;
        end else if (Pending[4]) begin
            Grant[4] = 1'b1;
            Sel_Word = CMD_4;
        end
    end

    assign Issue    = (State == ST_IDLE) && ((Pending != 4'b0000) || Host_Xfer);
    assign Clr      = (State == ST_IDLE) ? Grant : 4'b0000;
    assign Drop_Inc = {2'b00, Drop[1]} + {2'b00, Drop[2]} + {2'b00, Drop[3]} + {2'b00, Drop[4]};

    // Issue FSM with registered command word, strobe and gap counter
    always_ff @(posedge Clk_In) begin
        if (Rst) begin
            State     <= ST_IDLE;
            Cmd_Out_Q <= '0;
            Cmd_En_Q  <= 1'b0;
            Gap_Cnt   <= '0;
        end else begin
            Cmd_En_Q <= 1'b0;
            case (State)
                ST_IDLE: begin
                    if (Issue) begin
                        Cmd_Out_Q <= Sel_Word;
                        Cmd_En_Q  <= 1'b1;
                        Gap_Cnt   <= GAP_CYC;
                        State     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (Gap_Cnt == 8'd0)
                        State <= ST_IDLE;
                    else
                        Gap_Cnt <= Gap_Cnt - 8'd1;
                end
                default: State <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of request edges lost on already-pending flags
    always_ff @(posedge Clk_In) begin
        if (Rst)
            Drop_Cnt <= '0;
        else
            Drop_Cnt <= sat_add8(Drop_Cnt, Drop_Inc);
    end

    assign Busy               = (State != ST_IDLE);
    assign Bus.Cmd_Out        = Cmd_Out_Q;
    assign Bus.Cmd_En         = Cmd_En_Q;
    assign Bus.Host_Cmd_Ready = Host_Ready;
endmodule

// File: tb/tb_cmd_word_issuer.sv
// Self-checking bench for cmd_word_issuer (GAP_CYC = 12, default codes).
// Table-driven per-cycle vectors for single request and priority, then
// hand-written sequences for drops, saturation, reset and the host port.
module tb_cmd_word_issuer;
    import dif_cmd_pkg::*;

`ifdef CMD_ISSUER_HOST_PORT_EN
    localparam logic HOST_EN = 1'b1;
`else
    localparam logic HOST_EN = 1'b0;
`endif

    logic       Clk_In = 1'b0;
    logic       Rst;
    logic [4:1] Req_In;
    logic       Busy;
    logic [8:1] Drop_Cnt;

    cmd_word_issuer_if Bus ();

    cmd_word_issuer dut (
        .Clk_In   (Clk_In),
        .Rst      (Rst),
        .Req_In   (Req_In),
        .Bus      (Bus),
        .Busy     (Busy),
        .Drop_Cnt (Drop_Cnt)
    );

    always #5 Clk_In = ~Clk_In;

    typedef struct {
        logic [4:1]  req;
        logic        en;
        logic [16:1] out;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge Clk_In);
        #1;
    endtask

    task automatic add_vec(input logic [4:1] r, input logic e, input logic [16:1] o, input logic b);
        vec_t v;
        v.req  = r;
        v.en   = e;
        v.out  = o;
        v.busy = b;
        vecs.push_back(v);
    endtask

    // Watch the bus for n cycles and count strobes
    task automatic count_strobes(input int n, output int total, output int n3);
        total = 0;
        n3    = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (Bus.Cmd_En === 1'b1) begin
                total++;
                if (Bus.Cmd_Out === 16'h0003) n3++;
            end
        end
    endtask

    initial begin
        int total;
        int n3;
        int waited;

        Rst                = 1'b1;
        Req_In             = 4'b0000;
        Bus.Host_Cmd_In    = 16'h0000;
        Bus.Host_Cmd_Valid = 1'b0;

        // Single request on line 2: strobe two cycles after the edge, 13 busy cycles
        add_vec(4'b0000, 1'b0, 16'h0000, 1'b0);
        add_vec(4'b0000, 1'b0, 16'h0000, 1'b0);
        add_vec(4'b0010, 1'b0, 16'h0000, 1'b0);
        add_vec(4'b0010, 1'b1, 16'h0002, 1'b1);
        for (int i = 0; i < 12; i++) add_vec(4'b0010, 1'b0, 16'h0002, 1'b1);
        add_vec(4'b0010, 1'b0, 16'h0002, 1'b0);
        add_vec(4'b0000, 1'b0, 16'h0002, 1'b0);
        // Lines 1 and 4 together: 0001 first, 0004 fourteen cycles later
        add_vec(4'b1001, 1'b0, 16'h0002, 1'b0);
        add_vec(4'b1001, 1'b1, 16'h0001, 1'b1);
        for (int i = 0; i < 12; i++) add_vec(4'b1001, 1'b0, 16'h0001, 1'b1);
        add_vec(4'b1001, 1'b0, 16'h0001, 1'b0);
        add_vec(4'b1001, 1'b1, 16'h0004, 1'b1);
        for (int i = 0; i < 12; i++) add_vec(4'b1001, 1'b0, 16'h0004, 1'b1);
        add_vec(4'b0000, 1'b0, 16'h0004, 1'b0);
        add_vec(4'b0000, 1'b0, 16'h0004, 1'b0);

        // Reset state
        tick();
        tick();
        check("rst_cmd_en", {31'd0, Bus.Cmd_En}, 32'd0);
        check("rst_cmd_out", {16'd0, Bus.Cmd_Out}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_drop_cnt", {24'd0, Drop_Cnt}, 32'd0);
        check("rst_ready", {31'd0, Bus.Host_Cmd_Ready}, {31'd0, HOST_EN});
        Rst = 1'b0;

        // Table-driven vectors
        foreach (vecs[i]) begin
            Req_In = vecs[i].req;
            tick();
            check($sformatf("vec%0d_en", i), {31'd0, Bus.Cmd_En}, {31'd0, vecs[i].en});
            check($sformatf("vec%0d_out", i), {16'd0, Bus.Cmd_Out}, {16'd0, vecs[i].out});
            check($sformatf("vec%0d_busy", i), {31'd0, Busy}, {31'd0, vecs[i].busy});
        end

        // Drop: two pulses on line 3 while in GAP -> one issue, one drop
        Req_In = 4'b0001;
        tick();
        tick();
        check("drop_first_en", {31'd0, Bus.Cmd_En}, 32'd1);
        check("drop_first_out", {16'd0, Bus.Cmd_Out}, 32'h0001);
        Req_In = 4'b0101;
        tick();
        Req_In = 4'b0001;
        tick();
        check("drop_cnt_before", {24'd0, Drop_Cnt}, 32'd0);
        Req_In = 4'b0101;
        tick();
        Req_In = 4'b0001;
        check("drop_cnt_one", {24'd0, Drop_Cnt}, 32'd1);
        count_strobes(40, total, n3);
        check("drop_issue_count", total, 32'd1);
        check("drop_issue_cmd3", n3, 32'd1);
        check("drop_cnt_after", {24'd0, Drop_Cnt}, 32'd1);

        // Saturation: 400 pulses every 2 cycles; at most one per 14 cycles is issued,
        // so well over 255 edges land on a pending flag
        for (int i = 0; i < 400; i++) begin
            Req_In = 4'b0101;
            tick();
            Req_In = 4'b0001;
            tick();
        end
        check("drop_cnt_sat", {24'd0, Drop_Cnt}, 32'd255);
        Req_In = 4'b0000;
        for (int i = 0; i < 40; i++) tick();
        check("drop_cnt_hold", {24'd0, Drop_Cnt}, 32'd255);
        check("drain_idle", {31'd0, Busy}, 32'd0);

        // Reset mid-GAP with flag 2 pending and line 1 held high
        Req_In = 4'b0001;
        tick();
        tick();
        check("pre_rst_en", {31'd0, Bus.Cmd_En}, 32'd1);
        Req_In = 4'b0011;
        tick();
        Rst = 1'b1;
        tick();
        check("mid_rst_en", {31'd0, Bus.Cmd_En}, 32'd0);
        check("mid_rst_out", {16'd0, Bus.Cmd_Out}, 32'd0);
        check("mid_rst_busy", {31'd0, Busy}, 32'd0);
        check("mid_rst_drop", {24'd0, Drop_Cnt}, 32'd0);
        Rst = 1'b0;
        count_strobes(40, total, n3);
        check("post_rst_no_strobe", total, 32'd0);
        Req_In = 4'b0010;
        tick();
        Req_In = 4'b0011;
        tick();
        check("rearm_no_en_yet", {31'd0, Bus.Cmd_En}, 32'd0);
        tick();
        check("rearm_en", {31'd0, Bus.Cmd_En}, 32'd1);
        check("rearm_out", {16'd0, Bus.Cmd_Out}, 32'h0001);
        Req_In = 4'b0000;
        for (int i = 0; i < 20; i++) tick();

`ifdef CMD_ISSUER_HOST_PORT_EN
        // Host word offered while flag 1 is pending: waits for 0001 and its gap
        check("host_idle_ready", {31'd0, Bus.Host_Cmd_Ready}, 32'd1);
        Req_In = 4'b0001;
        tick();
        Bus.Host_Cmd_In    = 16'hA5A5;
        Bus.Host_Cmd_Valid = 1'b1;
        check("host_ready_pending", {31'd0, Bus.Host_Cmd_Ready}, 32'd0);
        tick();
        check("host_req_en", {31'd0, Bus.Cmd_En}, 32'd1);
        check("host_req_out", {16'd0, Bus.Cmd_Out}, 32'h0001);
        waited = 0;
        total  = 0;
        while (Bus.Host_Cmd_Ready !== 1'b1 && waited < 40) begin
            tick();
            waited++;
            if (Bus.Cmd_En === 1'b1) total++;
        end
        check("host_ready_wait", waited, 32'd13);
        check("host_no_early_strobe", total, 32'd0);
        tick();
        Bus.Host_Cmd_Valid = 1'b0;
        check("host_en", {31'd0, Bus.Cmd_En}, 32'd1);
        check("host_out", {16'd0, Bus.Cmd_Out}, 32'hA5A5);
        check("host_ready_busy", {31'd0, Bus.Host_Cmd_Ready}, 32'd0);
        Req_In = 4'b0000;
        count_strobes(20, total, n3);
        check("host_single_strobe", total, 32'd0);
`else
        // Host port disabled: Valid is ignored, Ready stays low
        Bus.Host_Cmd_In    = 16'hBEEF;
        Bus.Host_Cmd_Valid = 1'b1;
        tick();
        check("nohost_ready", {31'd0, Bus.Host_Cmd_Ready}, 32'd0);
        count_strobes(20, total, n3);
        check("nohost_no_strobe", total, 32'd0);
        check("nohost_busy", {31'd0, Busy}, 32'd0);
        Bus.Host_Cmd_Valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cmd_word_issuer.md
# cmd_word_issuer

Transmit-side command source for the DIF command bus. It turns rising edges on four internal request lines, plus an optional host word port, into 16-bit command words with a one-cycle `Cmd_En` strobe. Consecutive strobes are spaced so every downstream command decoder has left its hold window before the next word arrives. It sits between the control/slow-control logic and the shared `Cmd_In`/`Cmd_En` bus.

## Interface
- `CMD_1`, default 16'h0001: code issued for `Req_In[1]`.
- `CMD_2`, default 16'h0002: code issued for `Req_In[2]`.
- `CMD_3`, default 16'h0003: code issued for `Req_In[3]`.
- `CMD_4`, default 16'h0004: code issued for `Req_In[4]`.
- `GAP_CYC`, default 8'd12: idle cycles forced after each strobe. Legal range is 1..255.
- `Clk_In` in 1: system clock; all logic is on the rising edge.
- `Rst` in 1: reset, synchronous and active-high.
- `Req_In` in [4:1]: request levels; each rising edge requests its command once.
- `Host_Cmd_In` in [16:1]: host-supplied command word.
- `Host_Cmd_Valid` in 1: host word valid.
- `Host_Cmd_Ready` out 1: host word accepted when both Valid and Ready are high.
- `Cmd_Out` out [16:1]: command word; holds its last value between strobes.
- `Cmd_En` out 1: one-cycle strobe qualifying `Cmd_Out`.
- `Busy` out 1: high whenever the state is not IDLE.
- `Drop_Cnt` out [8:1]: saturating count of lost request edges.

## Operation
- Edge detect: `Req_Q` registers `Req_In`. A bit's edge is `Req_In & ~Req_Q`.
- Pending flags (4 bits):
  - An edge sets its flag.
  - Issuing the command clears the flag.
  - If an edge and the issue-clear hit the same bit in the same cycle, the set wins and the edge is not counted as dropped.
  - An edge on a bit that is already pending and not being cleared increments `Drop_Cnt`. The count saturates at 255.
- Arbitration in IDLE uses fixed priority: pending[1] > [2] > [3] > [4] > host word.
- `Host_Cmd_Ready` = (state == IDLE) && (no pending flags). It is combinational from registers and never depends on `Host_Cmd_Valid`.
- States:
  - IDLE: if any flag is set or a host transfer occurs, register the selected word into `Cmd_Out`, assert `Cmd_En`, load the gap counter with `GAP_CYC`, and go to GAP. Otherwise stay in IDLE.
  - GAP: `Cmd_En`=0. Decrement the counter. When it reaches 0, go to IDLE.
- Reset values: state IDLE; `Cmd_Out`=0; `Cmd_En`=0; `Busy`=0; `Drop_Cnt`=0; pending flags=0. `Req_Q` resets to 4'b1111, so a level held high through reset produces no edge.
- `Rst` asserted mid-GAP or during a strobe: the next edge applies the reset values and pending requests are discarded.

## Timing
- Request latency: an edge sampled at cycle t sets its flag at t+1, and `Cmd_En` is high at t+2 if the block is idle and no higher-priority request is pending.
- Host latency: a transfer at cycle t drives `Cmd_En` at t+1.
- `Cmd_En` is high for exactly one cycle.
- Minimum strobe-to-strobe spacing is `GAP_CYC`+2 cycles. `Busy` is high for `GAP_CYC`+1 cycles per command.

## Configuration
- `CMD_ISSUER_HOST_PORT_EN` defined: the host path is built as described above.
- Not defined: ports remain, `Host_Cmd_Ready` is tied to 0, `Host_Cmd_In`/`Host_Cmd_Valid` are ignored, and arbitration covers only the four request flags.

## Structure
- Shared package `dif_cmd_pkg` holds:
  - the state encoding (IDLE, GAP) as `localparam [1:0]`;
  - the default command codes;
  - the default gap length.

  The matching command decoders use the same codes.
- One sub-module, `cmd_req_latch`, one instance per request line. It contains the edge register, the pending flag with set-wins rule, and the drop pulse output.
- The top level holds the arbiter, the FSM, the gap counter and the saturating counter.

## Test plan
- Single request, `GAP_CYC`=12: `Req_In[2]` rises at cycle 10 → `Cmd_En`=1 with `Cmd_Out`=16'h0002 at cycle 12 only; `Busy` high cycles 12–24.
- Priority: `Req_In[4]` and `Req_In[1]` rise together → 16'h0001 strobes first, 16'h0004 strobes 14 cycles later.
- Drop: `Req_In[3]` pulses twice while in GAP from an earlier command → one 16'h0003 issued; `Drop_Cnt`=1. Drive 300 such drops → `Drop_Cnt`=255.
- Host handshake (macro defined): Valid with 16'hA5A5 while flag[1] is pending → Ready stays 0 until after 16'h0001 and its gap; then the A5A5 strobe occurs one cycle after acceptance.
- Reset mid-GAP with flag[2] pending and `Req_In[1]` held high → no strobes after reset; outputs return to their reset values; no command issued for `Req_In[1]` until it falls and rises again.
- Macro undefined: `Host_Cmd_Valid`=1 → `Host_Cmd_Ready`=0 and no strobe.
